// File: rtl/lut_neuron_array_rt_if.sv
// lut_neuron_array_rt_if: config port plus input/output valid-ready streams of the LUT neuron array.
interface lut_neuron_array_rt_if #(
   parameter int IN_BITS = 8,
   parameter int OUT_BITS = 1,
   parameter int N_NEURONS = 4,
   parameter int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
);
   logic cfg_we;
   logic [NW-1:0] cfg_neuron;
   logic [IN_BITS-1:0] cfg_addr;
   logic [OUT_BITS-1:0] cfg_data;
   logic cfg_ready;
   logic in_valid;
   logic in_ready;
   logic [N_NEURONS*IN_BITS-1:0] in_data;
   logic out_valid;
   logic out_ready;
   logic [N_NEURONS*OUT_BITS-1:0] out_data;
   modport slave (
      input cfg_we, cfg_neuron, cfg_addr, cfg_data, in_valid, in_data, out_ready,
      output cfg_ready, in_ready, out_valid, out_data
   );
   modport master (
      output cfg_we, cfg_neuron, cfg_addr, cfg_data, in_valid, in_data, out_ready,
      input cfg_ready, in_ready, out_valid, out_data
   );
endinterface

// File: rtl/lut_neuron_array_rt.sv
// lut_neuron_array_rt: runtime-loadable per-neuron truth tables evaluated in parallel through a 2-stage pipeline.
module lut_neuron_array_rt #(
   parameter int IN_BITS = 8,
   parameter int OUT_BITS = 1,
   parameter int N_NEURONS = 4
) (
   input logic clk,
   input logic rst,
   lut_neuron_array_rt_if.slave bus
);
   localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
   localparam int DEPTH = 2 ** IN_BITS;
   typedef enum logic {CLEAR, RUN} state_t;
   state_t state_q, state_d;
   logic [IN_BITS-1:0] clr_q, clr_d;
   logic v1_q, v1_d, v2_q, v2_d, cfg_ready_q, cfg_ready_d;
   logic [N_NEURONS*IN_BITS-1:0] addr_q, addr_d;
   logic [N_NEURONS*OUT_BITS-1:0] out_q, out_d, rd;
   logic [N_NEURONS-1:0] we;
   logic [IN_BITS-1:0] waddr;
   logic [OUT_BITS-1:0] wdata;
   logic run, en, acc;
   always_comb begin
      run = state_q == RUN;
      en = !v2_q || bus.out_ready;
      acc = bus.in_valid && run && en;
      waddr = run ? bus.cfg_addr : clr_q;
      wdata = run ? bus.cfg_data : '0;
      // out-of-range neuron indices match no table, so such writes vanish
      for (int i = 0; i < N_NEURONS; i++) we[i] = run ? bus.cfg_we && bus.cfg_neuron == NW'(i) : 1'b1;
      clr_d = run ? clr_q : clr_q + 1'b1;
      state_d = (run || &clr_q) ? RUN : CLEAR;
      cfg_ready_d = state_d == RUN;
      v1_d = en ? acc : v1_q;
      addr_d = acc ? bus.in_data : addr_q;
      v2_d = en ? v1_q : v2_q;
      out_d = (en && v1_q) ? rd : out_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         clr_q <= '0;
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         out_q <= '0;
         cfg_ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         clr_q <= clr_d;
         v1_q <= v1_d;
         v2_q <= v2_d;
         out_q <= out_d;
         cfg_ready_q <= cfg_ready_d;
      end
      addr_q <= addr_d;
   end
   // reads sample the table before this edge's write lands, giving read-old on collision
   for (genvar g = 0; g < N_NEURONS; g++) begin : g_n
      (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem [DEPTH];
      always_ff @(posedge clk) if (we[g]) mem[waddr] <= wdata;
      assign rd[g*OUT_BITS +: OUT_BITS] = mem[addr_q[g*IN_BITS +: IN_BITS]];
   end
   assign bus.in_ready = run && en;
   assign bus.cfg_ready = cfg_ready_q;
   assign bus.out_valid = v2_q;
   assign bus.out_data = out_q;
endmodule

// File: tb/tb_lut_neuron_array_rt.sv
// tb_lut_neuron_array_rt: directed vector table plus streaming, backpressure, collision and reset sequences.
module tb_lut_neuron_array_rt;
   logic clk, rst;
   int checks = 0, errors = 0;
   bit mdl [4][256];
   logic [7:0] hot [4] = '{8'h11, 8'h98, 8'hFF, 8'h40};
   typedef struct { logic [31:0] din; logic [3:0] exp; } vec_t;
   vec_t vecs [6];
   lut_neuron_array_rt_if #(.IN_BITS(8), .OUT_BITS(1), .N_NEURONS(4)) ifc ();
   lut_neuron_array_rt_if #(.IN_BITS(2), .OUT_BITS(1), .N_NEURONS(3)) ifs ();
   lut_neuron_array_rt #(.IN_BITS(8), .OUT_BITS(1), .N_NEURONS(4)) dut (.clk(clk), .rst(rst), .bus(ifc));
   lut_neuron_array_rt #(.IN_BITS(2), .OUT_BITS(1), .N_NEURONS(3)) dut3 (.clk(clk), .rst(rst), .bus(ifs));
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [3:0] model(input logic [31:0] d);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = mdl[i][d[i*8 +: 8]];
      return r;
   endfunction
   function automatic logic [7:0] pick();
      return ($urandom_range(0, 1) != 0) ? hot[$urandom_range(0, 3)] : 8'($urandom);
   endfunction
   task automatic cfg(input int n, input logic [7:0] a, input logic d);
      ifc.cfg_we = 1'b1;
      ifc.cfg_neuron = 2'(n);
      ifc.cfg_addr = a;
      ifc.cfg_data = d;
      tick();
      ifc.cfg_we = 1'b0;
      mdl[n][a] = d;
   endtask
   task automatic wait_clear(output int cnt);
      cnt = 0;
      while (!ifc.in_ready && cnt < 1000) begin
         cnt++;
         tick();
      end
   endtask
   task automatic lookup(input logic [31:0] d, output logic [3:0] r, output logic v);
      int n = 0;
      ifc.in_valid = 1'b1;
      ifc.in_data = d;
      ifc.out_ready = 1'b1;
      #1;
      while (!ifc.in_ready && n < 20) begin
         n++;
         tick();
      end
      tick();
      ifc.in_valid = 1'b0;
      v = ifc.out_valid;
      chk("lat_not_early", 32'(v), 32'(0));
      tick();
      v = ifc.out_valid;
      r = ifc.out_data;
   endtask
   task automatic stream(input int n, input int mode);
      logic [3:0] q [$];
      logic [3:0] held;
      logic stall, acc, fire;
      int sent = 0, got = 0, cyc = 0;
      while (got < n && cyc < 4 * n + 100) begin
         ifc.in_valid = (sent < n) && (mode != 2 || $urandom_range(0, 3) != 0);
         ifc.in_data = {pick(), pick(), pick(), pick()};
         ifc.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? !(cyc >= 40 && cyc < 45) : 1'($urandom_range(0, 1));
         #1;
         stall = ifc.out_valid && !ifc.out_ready;
         chk("in_ready", 32'(ifc.in_ready), 32'(!stall));
         if (mode == 0) chk("no_bubble", 32'(ifc.out_valid), 32'(cyc >= 2));
         acc = ifc.in_valid && ifc.in_ready;
         fire = ifc.out_valid && ifc.out_ready;
         held = ifc.out_data;
         if (fire) begin
            chk("out_expected", 32'(q.size() > 0), 32'(1));
            if (q.size() > 0) chk("stream_data", 32'(ifc.out_data), 32'(q.pop_front()));
            got++;
         end
         if (acc) begin
            q.push_back(model(ifc.in_data));
            sent++;
         end
         tick();
         if (stall) begin
            chk("hold_valid", 32'(ifc.out_valid), 32'(1));
            chk("hold_data", 32'(ifc.out_data), 32'(held));
         end
         cyc++;
      end
      chk("stream_count", 32'(got), 32'(n));
      ifc.in_valid = 1'b0;
      ifc.out_ready = 1'b1;
      #1;
      chk("drained", 32'(ifc.out_valid), 32'(0));
   endtask
   initial begin
      int cnt;
      logic [3:0] r;
      logic v;
      vecs = '{
         '{32'hFF980011, 4'hD},
         '{32'h00989898, 4'h6},
         '{32'hFFFFFFFF, 4'h8},
         '{32'h00000011, 4'h1},
         '{32'h98119811, 4'h3},
         '{32'h1100FF98, 4'h0}
      };
      {ifc.cfg_we, ifc.cfg_neuron, ifc.cfg_addr, ifc.cfg_data} = '0;
      {ifc.in_valid, ifc.in_data, ifc.out_ready} = '0;
      {ifs.cfg_we, ifs.cfg_neuron, ifs.cfg_addr, ifs.cfg_data} = '0;
      {ifs.in_valid, ifs.in_data, ifs.out_ready} = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_in_ready", 32'(ifc.in_ready), 32'(0));
      chk("rst_cfg_ready", 32'(ifc.cfg_ready), 32'(0));
      chk("rst_out_valid", 32'(ifc.out_valid), 32'(0));
      chk("rst_out_data", 32'(ifc.out_data), 32'(0));
      chk("rst_small_out_valid", 32'(ifs.out_valid), 32'(0));
      // writes and inputs offered during CLEAR must be ignored
      ifc.cfg_we = 1'b1;
      ifc.cfg_neuron = 2'd0;
      ifc.cfg_addr = 8'h05;
      ifc.cfg_data = 1'b1;
      ifc.in_valid = 1'b1;
      ifc.in_data = 32'h05050505;
      ifc.out_ready = 1'b1;
      #1;
      wait_clear(cnt);
      ifc.cfg_we = 1'b0;
      ifc.in_valid = 1'b0;
      chk("clear_cycles", 32'(cnt), 32'(256));
      chk("cfg_ready_run", 32'(ifc.cfg_ready), 32'(1));
      chk("no_accept_in_clear", 32'(ifc.out_valid), 32'(0));
      lookup(32'hFF980011, r, v);
      chk("post_clear_valid", 32'(v), 32'(1));
      chk("post_clear_data", 32'(r), 32'(0));
      lookup(32'h05050505, r, v);
      chk("clear_write_ignored", 32'(r), 32'(0));
      cfg(1, 8'h98, 1'b1);
      cfg(2, 8'h98, 1'b1);
      cfg(0, 8'h11, 1'b1);
      cfg(3, 8'hFF, 1'b1);
      for (int i = 0; i < 6; i++) begin
         lookup(vecs[i].din, r, v);
         chk("vec_valid", 32'(v), 32'(1));
         chk($sformatf("vec%0d_data", i), 32'(r), 32'(vecs[i].exp));
      end
      // collision: write n0[0x40] on the edge where S2 reads it
      ifc.in_valid = 1'b1;
      ifc.in_data = 32'h00000040;
      tick();
      ifc.cfg_we = 1'b1;
      ifc.cfg_neuron = 2'd0;
      ifc.cfg_addr = 8'h40;
      ifc.cfg_data = 1'b1;
      tick();
      ifc.cfg_we = 1'b0;
      ifc.in_valid = 1'b0;
      mdl[0][8'h40] = 1'b1;
      chk("coll_valid", 32'(ifc.out_valid), 32'(1));
      chk("coll_read_old", 32'(ifc.out_data), 32'(0));
      tick();
      chk("coll_next_valid", 32'(ifc.out_valid), 32'(1));
      chk("coll_read_new", 32'(ifc.out_data), 32'(1));
      tick();
      stream(300, 0);
      stream(60, 1);
      stream(200, 2);
      ifc.in_valid = 1'b1;
      ifc.in_data = 32'hFF980011;
      tick();
      tick();
      chk("pre_rst_v2", 32'(ifc.out_valid), 32'(1));
      rst = 1'b1;
      ifc.in_valid = 1'b0;
      tick();
      rst = 1'b0;
      chk("midrst_out_valid", 32'(ifc.out_valid), 32'(0));
      chk("midrst_in_ready", 32'(ifc.in_ready), 32'(0));
      chk("midrst_cfg_ready", 32'(ifc.cfg_ready), 32'(0));
      wait_clear(cnt);
      chk("reclear_cycles", 32'(cnt), 32'(256));
      lookup(32'hFF980011, r, v);
      chk("reclear_data_a", 32'(r), 32'(0));
      lookup(32'h00989840, r, v);
      chk("reclear_data_b", 32'(r), 32'(0));
      // small array: neuron index 3 does not exist and must change nothing
      chk("small_cfg_ready", 32'(ifs.cfg_ready), 32'(1));
      ifs.cfg_we = 1'b1;
      ifs.cfg_neuron = 2'd3;
      ifs.cfg_addr = 2'd1;
      ifs.cfg_data = 1'b1;
      tick();
      ifs.cfg_neuron = 2'd2;
      ifs.cfg_addr = 2'd2;
      tick();
      ifs.cfg_we = 1'b0;
      ifs.out_ready = 1'b1;
      ifs.in_valid = 1'b1;
      ifs.in_data = 6'b010101;
      tick();
      ifs.in_data = 6'b100101;
      tick();
      ifs.in_valid = 1'b0;
      chk("oob_write_discarded", 32'(ifs.out_data), 32'(3'b000));
      tick();
      chk("small_write_n2", 32'(ifs.out_data), 32'(3'b100));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
